// File: rtl/sync3_hs_ctrl_pkg.sv
// Shared types and defaults for the req/ack crossing controller.
// State encoding is fixed so it can be probed from a waveform.
package sync3_hs_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    ERR     = 2'd3
  } state_t;

  localparam int DEF_DW          = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/sync3_hs_ctrl_sync3_bit.sv
// Three-flop single-bit synchronizer.
// Every stage clears asynchronously on rst.
module sync3_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [2:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[1:0], d};
  end

  assign q = ff[2];

endmodule

// File: rtl/sync3_hs_ctrl.sv
// Source-side 4-phase req/ack controller for a multi-bit crossing.
// Holds the word on xfer_data, watches a synchronized ack, flags stalls.
module sync3_hs_ctrl
  import sync3_hs_ctrl_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          xfer_req,
  output logic [DW-1:0] xfer_data,
  input  logic          xfer_ack,
  output logic          done,
  output logic          busy,
  output logic          err,
  input  logic          err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DW-1:0]    data_n;
  logic             req_n, done_n, err_n;
  logic             ack_s, expired;

  sync3_bit u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (xfer_ack),
    .q   (ack_s)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    req_n   = xfer_req;
    done_n  = 1'b0;
    err_n   = err;
    data_n  = xfer_data;
    expired = TO_EN && (cnt == CNT_LAST);
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_n  = in_data;
          req_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = RELEASE;
        end else if (expired) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = ERR;
        end
      end
      ERR: begin
        // a still-high ack would look like a stale reply to the next word
        if (err_clr && !ack_s) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state)
      cnt_n = '0;
    else if (state == REQ || state == RELEASE)
      cnt_n = cnt + 1'b1;
    else
      cnt_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      xfer_req  <= req_n;
      xfer_data <= data_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_sync3_hs_ctrl.sv
// Bench for sync3_hs_ctrl: directed vector table, random traffic
// against a destination responder and scoreboard, async reset check.
module tb_sync3_hs_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        xfer_req;
  logic [31:0] xfer_data;
  logic        xfer_ack = 1'b0;
  logic        done;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  sync3_hs_ctrl #(.DW(32), .TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .xfer_req  (xfer_req),
    .xfer_data (xfer_data),
    .xfer_ack  (xfer_ack),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        a;
    logic        c;
    logic        bz;
    logic        rq;
    logic        dn;
    logic        er;
    logic [31:0] xd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic [31:0] d, logic a, logic c,
                              logic bz, logic rq, logic dn, logic er,
                              logic [31:0] xd);
    vec_t r;
    r.v = v; r.d = d; r.a = a; r.c = c;
    r.bz = bz; r.rq = rq; r.dn = dn; r.er = er; r.xd = xd;
    tbl.push_back(r);
  endfunction

  // random-phase model: scoreboard plus destination responder
  logic [31:0] held;
  bit          outst, prev_acc;
  int          acc_n, done_n, dphase, dcnt;

  task automatic rnd_cycle(input bit allow);
    logic v;
    @(posedge clk); #1;
    if (prev_acc) outst = 1'b1;
    prev_acc = 1'b0;
    if (done) begin
      chk("rnd_done_owed", 32'(outst), 32'd1);
      done_n++;
      outst = 1'b0;
    end
    chk("rnd_busy", 32'(busy), 32'(outst));
    chk("rnd_ready", 32'(in_ready), 32'(!outst));
    chk("rnd_err", 32'(err), 32'd0);
    if (outst) chk("rnd_data_hold", xfer_data, held);
    case (dphase)
      0: if (xfer_req) begin
        chk("rnd_dst_capture", xfer_data, held);
        dcnt = $urandom_range(0, 2);
        dphase = 1;
      end
      1: if (dcnt == 0) begin
        xfer_ack = 1'b1;
        dphase = 2;
      end else dcnt--;
      2: if (!xfer_req) begin
        dcnt = $urandom_range(0, 2);
        dphase = 3;
      end
      default: if (dcnt == 0) begin
        xfer_ack = 1'b0;
        dphase = 0;
      end else dcnt--;
    endcase
    v = allow && ($urandom_range(0, 3) != 0);
    in_valid = v;
    in_data  = $urandom;
    err_clr  = ($urandom_range(0, 15) == 0);
    if (v && in_ready) begin
      held = in_data;
      acc_n++;
      prev_acc = 1'b1;
    end
  endtask

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] J = 32'h11111111;
  localparam logic [31:0] B = 32'hA5A50001;
  localparam logic [31:0] T = 32'h00000BAD;
  localparam logic [31:0] N = 32'h12345678;

  initial begin
    // basic transfer; junk offered while busy must be ignored
    add(1, D, 0, 0, 1, 1, 0, 0, D);
    add(1, J, 0, 0, 1, 1, 0, 0, D);
    for (int i = 0; i < 3; i++) add(1, J, 1, 0, 1, 1, 0, 0, D);
    add(1, J, 1, 0, 1, 0, 0, 0, D);
    for (int i = 0; i < 3; i++) add(1, J, 0, 0, 1, 0, 0, 0, D);
    add(1, J, 0, 0, 0, 0, 1, 0, D);
    add(0, J, 0, 0, 0, 0, 0, 0, D);
    // ack_s arrives on the last allowed REQ cycle
    add(1, B, 0, 0, 1, 1, 0, 0, B);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 0, 0, B);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 1, 0, 0, B);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 0, B);
    add(0, 0, 0, 0, 0, 0, 1, 0, B);
    add(0, 0, 0, 0, 0, 0, 0, 0, B);
    // REQ timeout
    add(1, T, 0, 0, 1, 1, 0, 0, T);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 1, 1, 0, 0, T);
    add(0, 0, 0, 0, 1, 0, 0, 1, T);
    // recovery: clear ignored while ack_s high, honoured once low
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 0, 0, 1, T);
    add(0, 0, 1, 1, 1, 0, 0, 1, T);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 1, T);
    add(0, 0, 0, 1, 0, 0, 0, 0, T);
    add(1, N, 0, 0, 1, 1, 0, 0, N);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 1, 0, 0, N);
    add(0, 0, 1, 0, 1, 0, 0, 0, N);
    add(0, 0, 0, 1, 1, 0, 0, 0, N);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 1, 0, 0, 0, N);
    add(0, 0, 0, 0, 0, 0, 1, 0, N);
    add(0, 0, 0, 0, 0, 0, 0, 0, N);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(xfer_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data", xfer_data, 32'd0);

    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      xfer_ack = tbl[i].a;
      err_clr  = tbl[i].c;
      @(posedge clk); #1;
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("row%0d_ready", i), 32'(in_ready), 32'(!tbl[i].bz));
      chk($sformatf("row%0d_req", i), 32'(xfer_req), 32'(tbl[i].rq));
      chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("row%0d_data", i), xfer_data, tbl[i].xd);
    end

    outst = 1'b0; prev_acc = 1'b0; dphase = 0; dcnt = 0;
    acc_n = 0; done_n = 0; held = N;
    in_valid = 1'b0; xfer_ack = 1'b0; err_clr = 1'b0;
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
    for (int i = 0; i < 100 && (outst || prev_acc || dphase != 0); i++)
      rnd_cycle(1'b0);
    chk("drain", 32'(outst || prev_acc || dphase != 0), 32'd0);
    chk("rnd_count", 32'(done_n), 32'(acc_n));
    chk("rnd_traffic", 32'(acc_n > 100), 32'd1);

    in_valid = 1'b1; in_data = 32'hCAFE0001; err_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_req_before", 32'(xfer_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_req", 32'(xfer_req), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_ready_after", 32'(in_ready), 32'd1);
    chk("ar_data_after", xfer_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
